alu_result_bank: RTL and testbench
==================================

# alu_result_bank

Captures successive ALU results into a four-slot register bank whose outputs drive the result inputs of the 4:1 result-select mux. Instead of choosing one of four results for display, this block writes one result at a time into the next slot. Two debounced push-buttons control it: store and clear. It sits between the ALU output and the select mux, so an operator can latch up to four results and then browse them.

## Interface

Parameters:
- `N`, 9: result width in bits.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz). Minimum 2.

Ports:
- `clk`, input, 1: system clock. One clock domain for the whole block.
- `resetn`, input, 1: asynchronous, active-low reset.
- `store_n`, input, 1: raw store push-button, active-low, asynchronous to `clk`.
- `clear_n`, input, 1: raw clear push-button, active-low, asynchronous to `clk`.
- `data_in`, input, N: current ALU result, sampled on a store event.
- `result0`..`result3`, output, N each: slot contents, wired to the select mux inputs.
- `valid`, output, 4: bit i is high when slot i holds a captured result.
- `write_sel`, output, 2: index of the slot the next store writes.
- `store_pulse`, output, 1: one-cycle strobe, high in the cycle a store is applied.

## Operation

- Each button passes through a 2-flop synchronizer and then a debouncer. The debounced level resets to 1 (released).
- Debouncer counter:
  - Counts cycles in which the synchronized level differs from the debounced level.
  - Clears to 0 on any cycle where they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the synchronized value at the next edge and the counter clears.
- Press event: a debounced 1->0 transition produces a one-cycle registered `press` pulse. A release (0->1) produces nothing. Holding a button produces exactly one event.
- Store event, when store `press`=1 and clear `press`=0, at that edge:
  - `result[write_sel]` <= `data_in`.
  - `valid[write_sel]` <= 1.
  - `write_sel` <= `write_sel`+1, modulo 4 (3 wraps to 0).
  - If the bank is already full, the oldest slot is overwritten. This is a ring, with no stall and no error.
- Clear event: all results <= 0, `valid` <= 0, `write_sel` <= 0.
- Simultaneous store and clear presses in the same cycle: clear wins and the store is discarded.
- `store_pulse` equals the store debouncer's `press` output. It is asserted even when a coincident clear suppresses the write.
- Reset values:
  - `result0`..`result3` = 0.
  - `valid` = 4'b0000.
  - `write_sel` = 0.
  - `store_pulse` = 0.
  - Debounced levels = 1, counters = 0, synchronizer flops = 1.
- Reset asserted mid-debounce or mid-press: state returns to reset values immediately. A button still held low when reset deasserts is debounced as a fresh press, giving one event DEBOUNCE_CYCLES+2 cycles later.
- `data_in` has no timing requirement outside the store edge. The block does not register it.

## Timing

- Let edge 0 be the first `clk` edge that samples a raw button low; the raw input is low and stable from then on.
  - The synchronizer output goes low after edge 1.
  - The debounced level falls after edge DEBOUNCE_CYCLES+1.
  - `press` is high from edge DEBOUNCE_CYCLES+2 to edge DEBOUNCE_CYCLES+3.
  - The bank updates at edge DEBOUNCE_CYCLES+3.
- Any bounce shorter than DEBOUNCE_CYCLES cycles restarts the count and produces no event.
- Minimum spacing between two accepted presses of the same button is 2*DEBOUNCE_CYCLES cycles: one debounced release plus one debounced press.
- Outputs are registered and glitch-free, so they are safe to feed combinational mux logic directly.

## Structure

- Shared package `alu_bank_pkg` holds:
  - Default `N` = 9.
  - `NUM_SLOTS` = 4.
  - `SLOT_W` = 2.
  - The 50 MHz default for `DEBOUNCE_CYCLES`.
- Sub-module `key_debounce` (parameter `DEBOUNCE_CYCLES`) contains the synchronizer, counter, debounced level and `press` pulse. It is instantiated twice, once for `store_n` and once for `clear_n`.
- The top level holds the slot registers, `valid`, the `write_sel` pointer and the clear-priority logic.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.

- **Reset:** assert `resetn`=0 asynchronously mid-cycle. All outputs go to 0 without waiting for a clock edge, and `valid`=0000.
- **Single store:** `data_in`=9'h0A5, `store_n` held low. `store_pulse` is high for exactly one cycle at edge 6. At edge 7, `result0`=0A5, `valid`=0001 and `write_sel`=1. Holding the button longer produces no further writes.
- **Bounce rejection:** toggle `store_n` low 3 cycles, high 1 cycle, repeated 5 times, then release. There is no `store_pulse`, and the bank is unchanged.
- **Fill and wrap:** five clean presses with `data_in` = 1, 2, 3, 4, 5. Final state is `result0`=5, `result1`=2, `result2`=3, `result3`=4, `valid`=1111 and `write_sel`=1.
- **Clear:** after a fill, press `clear_n`. All slots read 0, `valid`=0000 and `write_sel`=0. The next store lands in `result0`.
- **Simultaneous press, then reset mid-press:**
  - Drive `store_n` and `clear_n` low on the same edge. `store_pulse` fires, but the bank ends cleared with no write.
  - Then pull `resetn` low during a store debounce count and release it with `store_n` still low. Exactly one store occurs, DEBOUNCE_CYCLES+3 edges after reset release.

Source files
------------

// File: rtl/alu_result_bank_pkg.sv
// alu_bank_pkg: shared sizing constants for the ALU result bank.
// Holds the default result width, the slot count and pointer width, and the
// 50 MHz default debounce length (10 ms).
package alu_bank_pkg;
    localparam int DEF_N        = 9;
    localparam int NUM_SLOTS    = 4;
    localparam int SLOT_W       = 2;
    localparam int DEF_DEBOUNCE = 500000;
endpackage

// File: rtl/alu_result_bank_if.sv
// alu_result_bank_if: button, ALU data and bank-output signals of the result bank.
// Ports (signals): store_n/clear_n raw active-low buttons, data_in ALU result,
// result0..result3 slot contents, valid slot-occupied mask, write_sel next slot,
// store_pulse one-cycle store strobe.
// master = stimulus side (drives buttons/data), slave = bank side.
interface alu_result_bank_if
    import alu_bank_pkg::*;
#(
    parameter int N = DEF_N
);
    logic                 store_n;
    logic                 clear_n;
    logic [N-1:0]         data_in;
    logic [N-1:0]         result0;
    logic [N-1:0]         result1;
    logic [N-1:0]         result2;
    logic [N-1:0]         result3;
    logic [NUM_SLOTS-1:0] valid;
    logic [SLOT_W-1:0]    write_sel;
    logic                 store_pulse;

    modport master (
        output store_n, clear_n, data_in,
        input  result0, result1, result2, result3, valid, write_sel, store_pulse
    );

    modport slave (
        input  store_n, clear_n, data_in,
        output result0, result1, result2, result3, valid, write_sel, store_pulse
    );
endinterface

// File: rtl/alu_result_bank_key_debounce.sv
// key_debounce: 2-flop synchronizer, stable-count debouncer and press pulse for one button.
// Ports: clk, resetn (async active-low), i_key_n raw active-low button,
// o_press one-cycle registered pulse on each debounced 1->0 transition.
module key_debounce
    import alu_bank_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_key_n,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_level_d;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync    <= 2'b11;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_cnt     <= '0;
            r_press   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_key_n};
            r_level_d <= r_level;
            // falling edge of the debounced level only; releases are ignored
            r_press   <= r_level_d & ~r_level;
            if (r_sync[1] == r_level)
                r_cnt <= '0;
            else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else
                r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_press = r_press;
endmodule

// File: rtl/alu_result_bank.sv
// alu_result_bank: four-slot ring of captured ALU results driven by debounced store/clear buttons.
// Ports: clk, resetn (async active-low), bus (slave modport): store_n/clear_n raw
// buttons, data_in ALU result, result0..result3 slots, valid mask, write_sel
// next slot, store_pulse store strobe.
module alu_result_bank
    import alu_bank_pkg::*;
#(
    parameter int N               = DEF_N,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
    input  logic               clk,
    input  logic               resetn,
    alu_result_bank_if.slave   bus
);
    logic                 w_store_press;
    logic                 w_clear_press;
    logic [N-1:0]         r_slot [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] r_valid;
    logic [SLOT_W-1:0]    r_wsel;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_store (
        .clk     (clk),
        .resetn  (resetn),
        .i_key_n (bus.store_n),
        .o_press (w_store_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk     (clk),
        .resetn  (resetn),
        .i_key_n (bus.clear_n),
        .o_press (w_clear_press)
    );

    // clear has priority; a full bank simply overwrites the oldest slot
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_SLOTS; i++) r_slot[i] <= '0;
            r_valid <= '0;
            r_wsel  <= '0;
        end else if (w_clear_press) begin
            for (int i = 0; i < NUM_SLOTS; i++) r_slot[i] <= '0;
            r_valid <= '0;
            r_wsel  <= '0;
        end else if (w_store_press) begin
            r_slot[r_wsel]  <= bus.data_in;
            r_valid[r_wsel] <= 1'b1;
            r_wsel          <= r_wsel + SLOT_W'(1);
        end
    end

    assign bus.result0     = r_slot[0];
    assign bus.result1     = r_slot[1];
    assign bus.result2     = r_slot[2];
    assign bus.result3     = r_slot[3];
    assign bus.valid       = r_valid;
    assign bus.write_sel   = r_wsel;
    // store_pulse still fires when a coincident clear discards the write
    assign bus.store_pulse = w_store_press;
endmodule

// File: tb/tb_alu_result_bank.sv
// tb_alu_result_bank: table-driven, scoreboard-checked bench for alu_result_bank (DEBOUNCE_CYCLES=4).
module tb_alu_result_bank;
    localparam int N = 9;
    localparam int D = 4;

    typedef struct {
        logic         s;
        logic         c;
        logic [N-1:0] d;
        logic [N-1:0] r0, r1, r2, r3;
        logic [3:0]   v;
        logic [1:0]   ws;
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t tbl [12];
    vec_t sb [$];

    alu_result_bank_if #(.N(N)) bus ();

    alu_result_bank #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input vec_t e);
        chk({tag, ".result0"}, 32'(bus.result0), 32'(e.r0));
        chk({tag, ".result1"}, 32'(bus.result1), 32'(e.r1));
        chk({tag, ".result2"}, 32'(bus.result2), 32'(e.r2));
        chk({tag, ".result3"}, 32'(bus.result3), 32'(e.r3));
        chk({tag, ".valid"}, 32'(bus.valid), 32'(e.v));
        chk({tag, ".write_sel"}, 32'(bus.write_sel), 32'(e.ws));
    endtask

    function automatic vec_t mk(input logic s, input logic c, input logic [N-1:0] d,
                                input logic [N-1:0] r0, input logic [N-1:0] r1,
                                input logic [N-1:0] r2, input logic [N-1:0] r3,
                                input logic [3:0] v, input logic [1:0] ws);
        vec_t t;
        t.s = s; t.c = c; t.d = d;
        t.r0 = r0; t.r1 = r1; t.r2 = r2; t.r3 = r3; t.v = v; t.ws = ws;
        return t;
    endfunction

    // Press starts right after a negedge, so the next posedge is edge 0.
    task automatic run_vec(input int idx, input vec_t t);
        vec_t e;
        string tag;
        tag = $sformatf("vec%0d", idx);
        bus.data_in = t.d;
        bus.store_n = ~t.s;
        bus.clear_n = ~t.c;
        sb.push_back(t);
        for (int k = 0; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s.pulse@%0d", tag, k), 32'(bus.store_pulse), 32'(t.s && k == 6));
            if (k == 7) chk_state({tag, ".edge7"}, sb[0]);
        end
        e = sb.pop_front();
        chk_state({tag, ".held"}, e);
        bus.store_n = 1'b1;
        bus.clear_n = 1'b1;
        repeat (2 * D + 6) @(negedge clk);
    endtask

    initial begin
        vec_t z, e;
        int   npulse, pk;
        z = mk(0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'd0);
        tbl[0]  = mk(1, 0, 9'h0A5, 9'h0A5, 0, 0, 0, 4'b0001, 2'd1);
        tbl[1]  = mk(0, 1, 9'h000, 0, 0, 0, 0, 4'b0000, 2'd0);
        tbl[2]  = mk(1, 0, 9'h001, 1, 0, 0, 0, 4'b0001, 2'd1);
        tbl[3]  = mk(1, 0, 9'h002, 1, 2, 0, 0, 4'b0011, 2'd2);
        tbl[4]  = mk(1, 0, 9'h003, 1, 2, 3, 0, 4'b0111, 2'd3);
        tbl[5]  = mk(1, 0, 9'h004, 1, 2, 3, 4, 4'b1111, 2'd0);
        tbl[6]  = mk(1, 0, 9'h005, 5, 2, 3, 4, 4'b1111, 2'd1);
        tbl[7]  = mk(0, 1, 9'h000, 0, 0, 0, 0, 4'b0000, 2'd0);
        tbl[8]  = mk(1, 0, 9'h1FF, 9'h1FF, 0, 0, 0, 4'b0001, 2'd1);
        tbl[9]  = mk(1, 0, 9'h033, 9'h1FF, 9'h033, 0, 0, 4'b0011, 2'd2);
        tbl[10] = mk(1, 1, 9'h077, 0, 0, 0, 0, 4'b0000, 2'd0);
        tbl[11] = mk(1, 0, 9'h00C, 9'h00C, 0, 0, 0, 4'b0001, 2'd1);

        bus.store_n = 1'b1;
        bus.clear_n = 1'b1;
        bus.data_in = '0;
        repeat (2) @(negedge clk);
        chk("reset.pulse", 32'(bus.store_pulse), 32'd0);
        chk_state("reset", z);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(i, tbl[i]);

        // bounce: 3 cycles low, 1 high, five times; no event must emerge
        npulse = 0;
        bus.data_in = 9'h155;
        for (int r = 0; r < 5; r++) begin
            bus.store_n = 1'b0;
            repeat (3) begin @(negedge clk); if (bus.store_pulse) npulse++; end
            bus.store_n = 1'b1;
            @(negedge clk); if (bus.store_pulse) npulse++;
        end
        repeat (12) begin @(negedge clk); if (bus.store_pulse) npulse++; end
        chk("bounce.pulses", 32'(npulse), 32'd0);
        chk_state("bounce", tbl[11]);

        // asynchronous reset mid-cycle, checked before the next edge
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("async_rst.pulse", 32'(bus.store_pulse), 32'd0);
        chk_state("async_rst", z);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // reset during a store debounce, released with the button still held
        bus.data_in = 9'h1AB;
        bus.store_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_state("rst_mid", z);
        resetn = 1'b1;
        npulse = 0;
        pk = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.store_pulse) begin npulse++; pk = k; end
            if (k == 7) begin
                e = mk(1, 0, 9'h1AB, 9'h1AB, 0, 0, 0, 4'b0001, 2'd1);
                chk_state("rst_mid.edge7", e);
            end
        end
        chk("rst_mid.pulses", 32'(npulse), 32'd1);
        chk("rst_mid.pulse_edge", 32'(pk), 32'd6);
        bus.store_n = 1'b1;
        chk("sb.empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
